dds_sweep_ctrl: RTL

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl_pkg.sv | 20 ++
 rtl/dds_dwell_timer.sv | 44 ++++
 rtl/dds_sweep_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared DDS sweep package: phase width constants and sweep FSM state encoding.
// MW defaults to ROM_PHASE_BIT-1 so the increment width tracks the phase ROM.
// Optional feature macro: DDS_SWEEP_BIDIR_EN (adds the StDown state).
package dds_sweep_ctrl_pkg;

  localparam int unsigned ROM_PHASE_BIT = 16;
  localparam int unsigned DDS_MW        = ROM_PHASE_BIT - 1;
  localparam int unsigned DDS_DW        = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDone = 2'd2
`ifdef DDS_SWEEP_BIDIR_EN
    ,
    StDown = 2'd3
`endif
  } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer for the DDS sweep: counts DDS sample ticks while enabled and
// emits a one-clk step strobe on the tick that completes the dwell period.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   en         counting enable; counter is held cleared while low
//   tick       DDS sample strobe
//   dwell      ticks per step (0 treated as 1)
//   step       combinational strobe, high on the completing tick
module dds_dwell_timer #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  input  logic [DW-1:0] dwell,
  output logic          step
);

  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] dwell_eff;
  logic          last;

  always_comb begin
    dwell_eff = (dwell == '0) ? DW'(1) : dwell;
    last      = (count_q == dwell_eff - DW'(1));
    step      = en & tick & last;
    count_d   = count_q;
    if (!en) begin
      count_d = '0;
    end else if (tick) begin
      count_d = last ? '0 : count_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller. On start, latches the sweep configuration and
// steps the phase increment phase_M from m_start towards m_stop by m_step every
// dwell ticks, clamping at m_stop. Optional loop restarts the sweep at the end.
// Optional feature macro: DDS_SWEEP_BIDIR_EN -- sweep back down to m_start after
// reaching m_stop.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   tick                       DDS sample strobe
//   start, stop                sweep start request / abort (stop has priority)
//   m_start, m_stop, m_step    sweep increment range and step size
//   dwell, loop                ticks per step, restart-at-end enable
//   phase_M, m_update          phase increment output and its change pulse
//   busy, done                 sweeping flag, normal completion pulse
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int unsigned MW = DDS_MW,
  parameter int unsigned DW = DDS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic [MW-1:0] m_start,
  input  logic [MW-1:0] m_stop,
  input  logic [MW-1:0] m_step,
  input  logic [DW-1:0] dwell,
  input  logic          loop,
  output logic [MW-1:0] phase_M,
  output logic          m_update,
  output logic          busy,
  output logic          done
);

  sweep_state_e  state_q, state_d;
  logic [MW-1:0] phase_q, phase_d;
  logic          upd_q, upd_d;
  logic [MW-1:0] m_start_q, m_stop_q, m_step_q;
  logic [DW-1:0] dwell_q;
  logic          loop_q;
  logic          load, degen, step, sweeping;
  logic [MW:0]   sum;
  logic [MW-1:0] up_val;

  assign load     = (state_q == StIdle) && start && !stop;
  assign degen    = (m_step == '0) || (m_stop <= m_start);
  assign sweeping = (state_q == StUp)
`ifdef DDS_SWEEP_BIDIR_EN
                    || (state_q == StDown)
`endif
                    ;

  // One extra bit so the add cannot wrap before the clamp.
  assign sum    = {1'b0, phase_q} + {1'b0, m_step_q};
  assign up_val = (sum >= {1'b0, m_stop_q}) ? m_stop_q : sum[MW-1:0];

`ifdef DDS_SWEEP_BIDIR_EN
  logic [MW:0]   diff;
  logic [MW-1:0] dn_val;
  // Borrow in the top bit means we went below zero; clamp at m_start either way.
  assign diff   = {1'b0, phase_q} - {1'b0, m_step_q};
  assign dn_val = (diff[MW] || (diff[MW-1:0] <= m_start_q)) ? m_start_q : diff[MW-1:0];
`endif

  dds_dwell_timer #(
    .DW(DW)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (sweeping),
    .tick (tick),
    .dwell(dwell_q),
    .step (step)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    upd_d   = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            phase_d = m_start;
            upd_d   = 1'b1;
            state_d = degen ? StDone : StUp;
          end
        end
        StUp: begin
          if (step) begin
            if (phase_q == m_stop_q) begin
`ifdef DDS_SWEEP_BIDIR_EN
              state_d = StDown;
              phase_d = dn_val;
              upd_d   = 1'b1;
`else
              if (loop_q) begin
                phase_d = m_start_q;
                upd_d   = 1'b1;
              end else begin
                state_d = StDone;
              end
`endif
            end else begin
              phase_d = up_val;
              upd_d   = 1'b1;
            end
          end
        end
`ifdef DDS_SWEEP_BIDIR_EN
        StDown: begin
          if (step) begin
            if (phase_q == m_start_q) begin
              if (loop_q) begin
                state_d = StUp;
                phase_d = up_val;
                upd_d   = 1'b1;
              end else begin
                state_d = StDone;
              end
            end else begin
              phase_d = dn_val;
              upd_d   = 1'b1;
            end
          end
        end
`endif
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      upd_q   <= upd_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_start_q <= '0;
      m_stop_q  <= '0;
      m_step_q  <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
    end else if (load) begin
      m_start_q <= m_start;
      m_stop_q  <= m_stop;
      m_step_q  <= m_step;
      dwell_q   <= dwell;
      loop_q    <= loop;
    end
  end

  assign phase_M  = phase_q;
  assign m_update = upd_q;
  assign busy     = sweeping;
  assign done     = (state_q == StDone);

endmodule
